// File: rtl/framing_pkg.sv
// Shared framing definitions for the UART deframer and the transmit-side framer:
// default delimiter bytes and the deframer state encoding.
package framing_pkg;

  localparam logic [7:0] DEF_START_BYTE = 8'hAA;
  localparam logic [7:0] DEF_END_BYTE   = 8'hBB;

  typedef enum logic [1:0] {
    HUNT      = 2'd0,
    GOT_START = 2'd1,
    GOT_B0    = 2'd2,
    GOT_B1    = 2'd3
  } deframer_state_e;

endpackage

// File: rtl/frame_timeout_timer.sv
// Inter-byte idle timer for the deframer. Counts idle cycles while a frame is
// open and flags the cycle in which the idle run reaches LIMIT cycles.
// Used only when DEFRAMER_TIMEOUT_EN is defined.
module frame_timeout_timer #(
  parameter logic [15:0] LIMIT = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Expiry is flagged on the idle cycle that finds the count at LIMIT-1.
  assign expired_o = run_i && (cnt_q == (LIMIT - 16'd1));

  // Next count: a byte or an idle hunt clears it, expiry restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_o) begin
      cnt_d = 16'd0;
    end else if (run_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_deframer.sv
// UART byte-stream deframer: START, low byte, high byte, END -> 16-bit word.
// Optional inter-byte timeout is compiled in with DEFRAMER_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------
// HUNT      | waiting for START_BYTE, other bytes dropped
// GOT_START | start seen, next byte is the low data byte
// GOT_B0    | low byte held, next byte is the high data byte
// GOT_B1    | both bytes held, next byte must be END_BYTE
module data_deframer
  import framing_pkg::*;
#(
  parameter logic [7:0]  START_BYTE     = DEF_START_BYTE,
  parameter logic [7:0]  END_BYTE       = DEF_END_BYTE,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_data_i,
  input  logic        uart_valid_i,
  output logic [15:0] data_o,
  output logic        valid_o,
  output logic        frame_err_o,
  output logic [7:0]  err_count_o
);

  deframer_state_e state_q, state_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  hi_q, hi_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        timeout_hit;

`ifdef DEFRAMER_TIMEOUT_EN
  frame_timeout_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (uart_valid_i || (state_q == HUNT)),
    .run_i     (!uart_valid_i && (state_q != HUNT)),
    .expired_o (timeout_hit)
  );
`else
  // Without the timer a partial frame simply waits for its next byte.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  // Next-state and output computation; a present byte always beats a timeout.
  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    if (uart_valid_i) begin
      unique case (state_q)
        HUNT: begin
          if (uart_data_i == START_BYTE) state_d = GOT_START;
        end
        GOT_START: begin
          lo_d    = uart_data_i;
          state_d = GOT_B0;
        end
        GOT_B0: begin
          hi_d    = uart_data_i;
          state_d = GOT_B1;
        end
        GOT_B1: begin
          if (uart_data_i == END_BYTE) begin
            data_d  = {hi_q, lo_q};
            valid_d = 1'b1;
            state_d = HUNT;
          end else begin
            err_d   = 1'b1;
            // A misplaced START is treated as the beginning of a new frame.
            state_d = (uart_data_i == START_BYTE) ? GOT_START : HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (timeout_hit) begin
      err_d   = 1'b1;
      state_d = HUNT;
    end
    if (err_d && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
  end

  // State, capture and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      lo_q    <= 8'd0;
      hi_q    <= 8'd0;
      data_q  <= 16'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = err_q;
  assign err_count_o = cnt_q;

endmodule

// File: doc/data_deframer.md
DATA_DEFRAMER -- requirements
Module: data_deframer

Interface
REQ-001 The block SHALL have parameter START_BYTE, default 8'hAA, meaning the frame start delimiter.
REQ-002 The block SHALL have parameter END_BYTE, default 8'hBB, meaning the frame end delimiter.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 16'd1000, meaning the maximum clk cycles allowed between consecutive bytes of one frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port uart_data_i, input, 8 bits: received UART byte.
REQ-007 The block SHALL have port uart_valid_i, input, 1 bit: uart_data_i is valid this cycle; one byte per asserted cycle.
REQ-008 The block SHALL have port data_o, output, 16 bits: last correctly framed word.
REQ-009 The block SHALL have port valid_o, output, 1 bit: one-cycle pulse marking a new data_o.
REQ-010 The block SHALL have port frame_err_o, output, 1 bit: one-cycle pulse on any framing error.
REQ-011 The block SHALL have port err_count_o, output, 8 bits: saturating count of framing errors.

Function
REQ-012 The FSM SHALL have exactly four states, with a byte meaning a cycle with uart_valid_i=1: HUNT, GOT_START, GOT_B0 and GOT_B1.
REQ-013 In HUNT, START_BYTE SHALL move the FSM to GOT_START; any other byte SHALL be discarded silently, with no error.
REQ-014 In GOT_START, a byte SHALL be captured as the low data byte and the FSM SHALL move to GOT_B0; no value check applies, so START_BYTE or END_BYTE are legal data.
REQ-015 In GOT_B0, a byte SHALL be captured as the high data byte and the FSM SHALL move to GOT_B1.
REQ-016 In GOT_B1, END_BYTE SHALL load data_o = {high,low}, pulse valid_o and move the FSM to HUNT.
REQ-017 In GOT_B1, a byte other than END_BYTE SHALL pulse frame_err_o and leave data_o unchanged; if that byte equals START_BYTE the FSM SHALL move to GOT_START (resync), otherwise to HUNT.
REQ-018 data_o, valid_o and frame_err_o SHALL all be registered outputs; valid_o and frame_err_o SHALL assert the cycle after the triggering byte, for one cycle only.
REQ-019 data_o SHALL hold its value between valid frames.
REQ-020 With no byte present, the FSM SHALL hold its state, subject to REQ-026.
REQ-021 err_count_o SHALL increment by 1 on every frame_err_o pulse and SHALL saturate at 8'hFF, with no wrap.
REQ-022 Back-to-back frames with no idle cycles SHALL be accepted at full byte rate, with no dead cycle required after END_BYTE.

Reset
REQ-023 When rst is asserted the FSM SHALL go to HUNT, and data_o, valid_o, frame_err_o, err_count_o, the captured bytes and the timeout counter SHALL all be zero.
REQ-024 Reset asserted mid-frame SHALL discard the partial frame and SHALL produce no valid_o or frame_err_o pulse.

Configuration
REQ-025 The macro DEFRAMER_TIMEOUT_EN SHALL compile the inter-byte timeout feature in or out.
REQ-026 With DEFRAMER_TIMEOUT_EN defined:
- A 16-bit counter SHALL clear on each byte and increment each idle cycle while the FSM is outside HUNT.
- When the counter reaches TIMEOUT_CYCLES-1, the block SHALL pulse frame_err_o, increment err_count_o and return the FSM to HUNT.
- If a byte arrives in the expiry cycle, the byte SHALL win: it is processed and no timeout occurs.
REQ-027 Without DEFRAMER_TIMEOUT_EN, the counter logic SHALL be absent and a partial frame SHALL wait indefinitely.

Structure
REQ-028 START_BYTE/END_BYTE default constants and the deframer state enum SHALL live in shared package framing_pkg, also used by the transmit-side framer.
REQ-029 The inter-byte timer SHALL be a sub-module named frame_timeout_timer, instantiated only under DEFRAMER_TIMEOUT_EN.

Verification
REQ-030 Bytes AA,34,12,BB -> data_o=16'h1234 and valid_o pulses once, one cycle after BB; frame_err_o stays 0.
REQ-031 Bytes 55,AA,BB,AA,BB -> the 55 is ignored; data_o=16'hAABB and valid_o pulses once; err_count_o=0.
REQ-032 Bytes AA,01,02,CC,AA,03,04,BB -> frame_err_o pulses after CC, err_count_o=1, then data_o=16'h0403 and valid_o pulses.
REQ-033 With DEFRAMER_TIMEOUT_EN and TIMEOUT_CYCLES=8: AA,01, then 8 idle cycles, then 02,BB -> frame_err_o pulses once, there is no valid_o, and the FSM is in HUNT.
REQ-034 Send 300 bad frames (AA,00,00,CC) -> err_count_o saturates at 8'hFF.
REQ-035 Bytes AA,34, then rst pulsed, then 12,BB -> no valid_o, no frame_err_o, data_o=0.
